// File: rtl/miner_pkg.sv
// Shared types and defaults for the miner core.
// Holds the hash/chunk/initial-hash types, the sequencer state enum, the default
// cycle counts and nonce position, and a helper that writes a nonce into a chunk.
package miner_pkg;

    localparam int unsigned MINER_MSA_CYCLES   = 48;
    localparam int unsigned MINER_COMP_CYCLES  = 64;
    localparam int unsigned MINER_NONCE_OFFSET = 96;
    localparam int unsigned NONCE_W            = 32;

    typedef logic [0:255]       hash_t;
    typedef logic [0:511]       chunk_t;
    typedef logic [0:7][0:31]   hword_arr_t;
    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MSA   = 3'd2,
        ST_COMP  = 3'd3,
        ST_ADD   = 3'd4,
        ST_CHECK = 3'd5,
        ST_DONE  = 3'd6
    } ctrl_state_t;

    // Bit 0 of the chunk is the MSB, so the nonce MSB lands at chunk[offset].
    function automatic chunk_t insert_nonce(input chunk_t tmpl, input nonce_t nonce,
                                            input logic [8:0] offset);
        chunk_t c;
        c = tmpl;
        c[offset +: NONCE_W] = nonce;
        return c;
    endfunction

endpackage

// File: rtl/miner_core_sha_ctrl_if.sv
// Bundle between the job issuer / SHA core side (master) and the sequencer (slave).
// Job side: start, abort, chunk_tmpl, fh_in, target, nonce_start, nonce_end in;
//           busy, done, found, nonce_out, hash_out back.
// Core side: h from the core; msa_en, comp_en, add_en, chunk, fh to the core.
interface miner_core_sha_ctrl_if;

    logic                 start;
    logic                 abort;
    miner_pkg::chunk_t    chunk_tmpl;
    miner_pkg::hword_arr_t fh_in;
    miner_pkg::hash_t     target;
    miner_pkg::nonce_t    nonce_start;
    miner_pkg::nonce_t    nonce_end;
    miner_pkg::hash_t     h;

    logic                 msa_en;
    logic                 comp_en;
    logic                 add_en;
    miner_pkg::chunk_t    chunk;
    miner_pkg::hword_arr_t fh;
    logic                 busy;
    logic                 done;
    logic                 found;
    miner_pkg::nonce_t    nonce_out;
    miner_pkg::hash_t     hash_out;

    modport master (
        output start, abort, chunk_tmpl, fh_in, target, nonce_start, nonce_end, h,
        input  msa_en, comp_en, add_en, chunk, fh, busy, done, found, nonce_out, hash_out
    );

    modport slave (
        input  start, abort, chunk_tmpl, fh_in, target, nonce_start, nonce_end, h,
        output msa_en, comp_en, add_en, chunk, fh, busy, done, found, nonce_out, hash_out
    );

endinterface

// File: rtl/miner_core_target_cmp.sv
// 256-bit unsigned less-than of a hash against a target (bit 0 is the MSB).
// Ports: hash, target in; lt_c out (combinational, 1 when hash < target).
module miner_core_target_cmp
    import miner_pkg::*;
(
    input  hash_t hash,
    input  hash_t target,
    output logic  lt_c
);

    assign lt_c = (hash < target);

endmodule

// File: rtl/miner_core_sha_ctrl.sv
// Nonce-sweeping sequencer for the SHA core: for each nonce in the job range it
// builds the chunk, runs schedule / compression / final-add, then compares h
// against the target and stops on a hit, at the end of the range, or on abort.
// Ports: clk, n_rst (async active-low); bus (slave side of miner_core_sha_ctrl_if)
//        carrying the job inputs, the core enables/chunk/fh, and the result outputs.
module miner_core_sha_ctrl
    import miner_pkg::*;
#(
    parameter int unsigned MSA_CYCLES   = MINER_MSA_CYCLES,   // >= 1
    parameter int unsigned COMP_CYCLES  = MINER_COMP_CYCLES,  // >= 1
    parameter int unsigned NONCE_OFFSET = MINER_NONCE_OFFSET  // 0..480
) (
    input  logic                 clk,
    input  logic                 n_rst,
    miner_core_sha_ctrl_if.slave bus
);

    localparam int unsigned CNT_MAX   = (MSA_CYCLES > COMP_CYCLES) ? MSA_CYCLES : COMP_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [8:0]  NONCE_POS = 9'(NONCE_OFFSET);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    chunk_t     tmpl_q, tmpl_d;
    nonce_t     nonce_q, nonce_d;
    nonce_t     nonce_end_q;
    hash_t      target_q;
    hword_arr_t fh_q;
    chunk_t     chunk_q;
    hash_t      hash_out_q;
    nonce_t     nonce_out_q;
    logic       msa_en_q, comp_en_q, add_en_q;
    logic       busy_q, done_q, found_q;

    logic accept_c;
    logic hit_c;
    logic last_c;
    logic check_c;

    miner_core_target_cmp u_cmp (
        .hash   (bus.h),
        .target (target_q),
        .lt_c   (hit_c)
    );

    assign last_c  = (nonce_q == nonce_end_q);
    assign check_c = (state_q == ST_CHECK) && !bus.abort;

    // Next-state, phase counter and next job/nonce values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        tmpl_d   = tmpl_q;
        nonce_d  = nonce_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_LOAD;
                    accept_c = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_MSA;
                cnt_d   = CNT_W'(MSA_CYCLES - 1);
            end
            ST_MSA: begin
                if (cnt_q == '0) begin
                    state_d = ST_COMP;
                    cnt_d   = CNT_W'(COMP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_COMP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ADD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ADD: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = (hit_c || last_c) ? ST_DONE : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle start.
        if (bus.abort) begin
            state_d  = ST_IDLE;
            accept_c = 1'b0;
        end

        if (accept_c) begin
            tmpl_d  = bus.chunk_tmpl;
            nonce_d = bus.nonce_start;
        end else if (check_c && !hit_c && !last_c) begin
            nonce_d = nonce_q + NONCE_W'(1);
        end
    end

    // State register and phase counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Job latches, chunk build and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmpl_q      <= '0;
            nonce_q     <= '0;
            nonce_end_q <= '0;
            target_q    <= '0;
            fh_q        <= '0;
            chunk_q     <= '0;
            hash_out_q  <= '0;
            nonce_out_q <= '0;
            msa_en_q    <= 1'b0;
            comp_en_q   <= 1'b0;
            add_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
        end else begin
            msa_en_q  <= (state_d == ST_MSA);
            comp_en_q <= (state_d == ST_COMP);
            add_en_q  <= (state_d == ST_ADD);
            busy_q    <= !((state_d == ST_IDLE) || (state_d == ST_DONE));
            done_q    <= (state_d == ST_DONE);

            tmpl_q  <= tmpl_d;
            nonce_q <= nonce_d;

            if (accept_c) begin
                fh_q        <= bus.fh_in;
                target_q    <= bus.target;
                nonce_end_q <= bus.nonce_end;
            end

            // Built on entry to LOAD so chunk is steady for LOAD through CHECK.
            if (state_d == ST_LOAD) begin
                chunk_q <= insert_nonce(tmpl_d, nonce_d, NONCE_POS);
            end

            if (check_c) begin
                hash_out_q  <= bus.h;
                nonce_out_q <= nonce_q;
            end

            if (accept_c || bus.abort) begin
                found_q <= 1'b0;
            end else if (check_c && hit_c) begin
                found_q <= 1'b1;
            end
        end
    end

    assign bus.msa_en    = msa_en_q;
    assign bus.comp_en   = comp_en_q;
    assign bus.add_en    = add_en_q;
    assign bus.chunk     = chunk_q;
    assign bus.fh        = fh_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.found     = found_q;
    assign bus.nonce_out = nonce_out_q;
    assign bus.hash_out  = hash_out_q;

endmodule

// File: tb/tb_miner_core_sha_ctrl.sv
// Bench for miner_core_sha_ctrl: plays the job issuer and a stand-in SHA core,
// pushes expected chunks and job results into queues, and a negedge monitor
// checks them when msa_en or done rises.
module tb_miner_core_sha_ctrl;
    import miner_pkg::*;

    localparam int unsigned PER_HASH = 115;

    typedef struct {
        logic        found;
        nonce_t      nonce;
        hash_t       hash;
        int unsigned hashes;
    } exp_t;

    typedef struct {
        chunk_t     chunk;
        hword_arr_t fh;
    } exp_chunk_t;

    logic clk;
    logic n_rst;

    miner_core_sha_ctrl_if bus ();

    miner_core_sha_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int unsigned n_cmp;
    int unsigned n_bad;
    exp_t        exp_q[$];
    exp_chunk_t  chk_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deterministic stand-in for the SHA result of a given nonce.
    function automatic hash_t model_hash(input nonce_t n);
        hash_t r;
        r = {n ^ 32'h0F0F_0F0F,
             (n + 32'd1) * 32'h9E37_79B9, (n + 32'd2) * 32'h9E37_79B9,
             (n + 32'd3) * 32'h9E37_79B9, (n + 32'd4) * 32'h9E37_79B9,
             (n + 32'd5) * 32'h9E37_79B9, (n + 32'd6) * 32'h9E37_79B9,
             (n + 32'd7) * 32'h9E37_79B9};
        return r;
    endfunction

    // Stand-in core: h is registered at the end of the add cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) bus.h <= '0;
        else if (bus.add_en) bus.h <= model_hash(bus.chunk[96 +: 32]);
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.done;
            1:       return bus.msa_en;
            default: return bus.comp_en;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int unsigned max_cyc, input string nm);
        int unsigned n;
        n = 0;
        while (!sig(sel) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout after %0d cycles", nm, n);
        end
    endtask

    task automatic push_chunks(input chunk_t tmpl, input hword_arr_t fhv,
                               input nonce_t first, input int unsigned count);
        exp_chunk_t e;
        nonce_t     n;
        n = first;
        for (int i = 0; i < int'(count); i++) begin
            e.chunk          = tmpl;
            e.chunk[96 +: 32] = n;
            e.fh             = fhv;
            chk_q.push_back(e);
            n = n + 32'd1;
        end
    endtask

    task automatic push_exp(input logic found, input nonce_t nonce, input int unsigned hashes);
        exp_t e;
        e.found  = found;
        e.nonce  = nonce;
        e.hash   = model_hash(nonce);
        e.hashes = hashes;
        exp_q.push_back(e);
    endtask

    // Pulse start with a job, then scramble the inputs to prove they were latched.
    task automatic launch(input hash_t tgt, input nonce_t ns, input nonce_t ne,
                          input chunk_t tmpl, input hword_arr_t fhv);
        @(posedge clk); #1;
        bus.target      = tgt;
        bus.nonce_start = ns;
        bus.nonce_end   = ne;
        bus.chunk_tmpl  = tmpl;
        bus.fh_in       = fhv;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.target      = ~tgt;
        bus.nonce_start = ~ns;
        bus.nonce_end   = ~ne;
        bus.chunk_tmpl  = ~tmpl;
        bus.fh_in       = ~fhv;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_msa_en"},    256'(bus.msa_en),    256'(0));
        check({nm, "_comp_en"},   256'(bus.comp_en),   256'(0));
        check({nm, "_add_en"},    256'(bus.add_en),    256'(0));
        check({nm, "_busy"},      256'(bus.busy),      256'(0));
        check({nm, "_done"},      256'(bus.done),      256'(0));
        check({nm, "_found"},     256'(bus.found),     256'(0));
        check({nm, "_nonce_out"}, 256'(bus.nonce_out), 256'(0));
        check({nm, "_hash_out"},  bus.hash_out,        256'(0));
        check({nm, "_chunk_hi"},  bus.chunk[0:255],    256'(0));
        check({nm, "_chunk_lo"},  bus.chunk[256:511],  256'(0));
        check({nm, "_fh"},        bus.fh,              256'(0));
    endtask

    // Monitor: checks chunk/fh on each hash start and the job result on done.
    initial begin
        logic        busy_q, msa_q, done_q;
        int unsigned busy_n, msa_n, comp_n, add_n, ovl_n;
        exp_t        e;
        exp_chunk_t  c;
        busy_q = 1'b0; msa_q = 1'b0; done_q = 1'b0;
        busy_n = 0; msa_n = 0; comp_n = 0; add_n = 0; ovl_n = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                busy_q = 1'b0; msa_q = 1'b0; done_q = 1'b0;
            end else begin
                if (bus.busy && !busy_q) begin
                    busy_n = 0; msa_n = 0; comp_n = 0; add_n = 0; ovl_n = 0;
                end
                if (bus.busy)    busy_n++;
                if (bus.msa_en)  msa_n++;
                if (bus.comp_en) comp_n++;
                if (bus.add_en)  add_n++;
                if ((32'(bus.msa_en) + 32'(bus.comp_en) + 32'(bus.add_en)) > 32'd1) ovl_n++;

                if (bus.msa_en && !msa_q) begin
                    if (chk_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL chunk_unexpected: hash started with nonce %0h", bus.chunk[96 +: 32]);
                    end else begin
                        c = chk_q.pop_front();
                        check("chunk_nonce", 256'(bus.chunk[96 +: 32]), 256'(c.chunk[96 +: 32]));
                        check("chunk_hi", bus.chunk[0:255],   c.chunk[0:255]);
                        check("chunk_lo", bus.chunk[256:511], c.chunk[256:511]);
                        check("fh",       bus.fh,             c.fh);
                    end
                end

                if (bus.done && !done_q) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL done_unexpected: nonce_out %0h", bus.nonce_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("found",       256'(bus.found),     256'(e.found));
                        check("nonce_out",   256'(bus.nonce_out), 256'(e.nonce));
                        check("hash_out",    bus.hash_out,        e.hash);
                        check("busy_cycles", 256'(busy_n),        256'(e.hashes * PER_HASH));
                        check("msa_cycles",  256'(msa_n),         256'(e.hashes * 48));
                        check("comp_cycles", 256'(comp_n),        256'(e.hashes * 64));
                        check("add_cycles",  256'(add_n),         256'(e.hashes));
                        check("en_overlap",  256'(ovl_n),         256'(0));
                    end
                end
                busy_q = bus.busy;
                msa_q  = bus.msa_en;
                done_q = bus.done;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        chunk_t     tmpl;
        hword_arr_t fhv;
        n_cmp = 0;
        n_bad = 0;
        n_rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.chunk_tmpl = '0; bus.fh_in = '0; bus.target = '0;
        bus.nonce_start = '0; bus.nonce_end = '0;

        #12;
        check_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Hit on the first nonce with an all-ones target.
        tmpl = {16{32'hC0DE_0001}};
        fhv  = {8{32'h6A09_E667}};
        push_chunks(tmpl, fhv, 32'd5, 1);
        push_exp(1'b1, 32'd5, 1);
        launch('1, 32'd5, 32'd9, tmpl, fhv);
        wait_for(0, PER_HASH + 20, "t1_done");
        repeat (5) @(negedge clk);
        check("t1_done_held",  256'(bus.done),  256'(1));
        check("t1_found_held", 256'(bus.found), 256'(1));

        // Abort from DONE clears done/found but keeps the results.
        pulse_abort();
        @(negedge clk);
        check("abort_done_done",  256'(bus.done),      256'(0));
        check("abort_done_found", 256'(bus.found),     256'(0));
        check("abort_done_nonce", 256'(bus.nonce_out), 256'(5));
        check("abort_done_busy",  256'(bus.busy),      256'(0));

        // Target 0: three misses to the end of the range.
        tmpl = {16{32'hC0DE_0002}};
        fhv  = {8{32'hBB67_AE85}};
        push_chunks(tmpl, fhv, 32'd0, 3);
        push_exp(1'b0, 32'd2, 3);
        launch('0, 32'd0, 32'd2, tmpl, fhv);
        wait_for(0, 3 * PER_HASH + 20, "t2_done");

        // Relaunch from DONE; hit exactly at nonce 7.
        tmpl = {16{32'hC0DE_0003}};
        fhv  = {8{32'h3C6E_F372}};
        push_chunks(tmpl, fhv, 32'd3, 5);
        push_exp(1'b1, 32'd7, 5);
        launch(hash_t'(model_hash(32'd7) + 256'd1), 32'd3, 32'd20, tmpl, fhv);
        wait_for(0, 5 * PER_HASH + 20, "t3_done");

        // Nonce wrap-around.
        tmpl = {16{32'hC0DE_0004}};
        fhv  = {8{32'hA54F_F53A}};
        push_chunks(tmpl, fhv, 32'hFFFF_FFFE, 4);
        push_exp(1'b0, 32'd1, 4);
        launch('0, 32'hFFFF_FFFE, 32'd1, tmpl, fhv);
        wait_for(0, 4 * PER_HASH + 20, "t4_done");

        // Single nonce whose hash equals the target: a miss.
        tmpl = {16{32'hC0DE_0005}};
        fhv  = {8{32'h510E_527F}};
        push_chunks(tmpl, fhv, 32'd50, 1);
        push_exp(1'b0, 32'd50, 1);
        launch(model_hash(32'd50), 32'd50, 32'd50, tmpl, fhv);
        wait_for(0, PER_HASH + 20, "t5_done");

        // Abort on the 30th compression cycle.
        tmpl = {16{32'hC0DE_0006}};
        fhv  = {8{32'h9B05_688C}};
        push_chunks(tmpl, fhv, 32'd200, 1);
        launch('0, 32'd200, 32'd210, tmpl, fhv);
        wait_for(2, 80, "t6_comp");
        repeat (29) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        check("abort_comp_busy",    256'(bus.busy),      256'(0));
        check("abort_comp_msa",     256'(bus.msa_en),    256'(0));
        check("abort_comp_comp",    256'(bus.comp_en),   256'(0));
        check("abort_comp_add",     256'(bus.add_en),    256'(0));
        check("abort_comp_done",    256'(bus.done),      256'(0));
        check("abort_comp_nonce",   256'(bus.nonce_out), 256'(50));
        check("abort_comp_hashout", bus.hash_out,        model_hash(32'd50));

        tmpl = {16{32'hC0DE_0007}};
        fhv  = {8{32'h1F83_D9AB}};
        push_chunks(tmpl, fhv, 32'd40, 1);
        push_exp(1'b1, 32'd40, 1);
        launch('1, 32'd40, 32'd40, tmpl, fhv);
        wait_for(0, PER_HASH + 20, "t6_relaunch_done");

        // Asynchronous reset in the middle of the schedule phase.
        tmpl = {16{32'hC0DE_0008}};
        fhv  = {8{32'h5BE0_CD19}};
        push_chunks(tmpl, fhv, 32'd300, 1);
        launch('0, 32'd300, 32'd305, tmpl, fhv);
        wait_for(1, 10, "t7_msa");
        repeat (10) @(posedge clk);
        #2 n_rst = 1'b0;
        #1 check_zero("mid_reset");
        @(posedge clk);
        #2 n_rst = 1'b1;

        // A second start while busy must not disturb the sweep.
        tmpl = {16{32'hC0DE_0009}};
        fhv  = {8{32'h0123_4567}};
        push_chunks(tmpl, fhv, 32'd10, 2);
        push_exp(1'b0, 32'd11, 2);
        launch('0, 32'd10, 32'd11, tmpl, fhv);
        wait_for(1, 10, "t8_msa");
        @(posedge clk); #1;
        bus.nonce_start = 32'd100;
        bus.nonce_end   = 32'd100;
        bus.target      = '1;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        wait_for(0, 2 * PER_HASH + 20, "t8_done");

        repeat (3) @(negedge clk);
        check("exp_q_empty",   256'(exp_q.size()), 256'(0));
        check("chunk_q_empty", 256'(chk_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
